// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg: shared definitions for the serial-sync frame transmitter.
//   - ftx_state_e  : FSM state encodings
//   - SYNC_PATTERN : 4-bit header sent ahead of every payload, MSB first
//   - SYNC_LEN     : header length in bits
//   - LINE_IDLE    : level held on the line between frames
//   - sync_bit()   : header bit for a given header index (0 = first on the line)
package frame_tx_pkg;

  typedef enum logic [2:0] {
    FTX_IDLE   = 3'd0,
    FTX_SYNC   = 3'd1,
    FTX_DATA   = 3'd2,
    FTX_PARITY = 3'd3,
    FTX_STOP   = 3'd4
  } ftx_state_e;

  localparam logic [3:0] SYNC_PATTERN = 4'b0110;
  localparam int         SYNC_LEN     = 4;
  localparam logic       LINE_IDLE    = 1'b1;

  // Header index 0 is the pattern MSB.
  function automatic logic sync_bit(input logic [1:0] idx);
    return SYNC_PATTERN[2'd3 - idx];
  endfunction

endpackage

// File: rtl/frame_tx_if.sv
// frame_tx_if: payload handshake into the frame transmitter.
//   tx_data  : payload word, sampled only on acceptance
//   tx_valid : payload offered
//   tx_ready : transmitter can accept; transfer on a rising edge with valid && ready
// master = producer side, slave = frame_tx side.
interface frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/frame_tx_bit_tick.sv
// frame_tx_bit_tick: bit-period divider for the frame transmitter.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous clear, restarts the bit period at count 0
//   strike_o : high in the last cycle of each CLKS_PER_BIT-cycle bit period
module frame_tx_bit_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic strike_o
);
  // Keep at least one counter bit so CLKS_PER_BIT=1 still elaborates.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign strike_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || strike_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame_tx.sv
// frame_tx: serial frame transmitter.
// Line format per frame: sync 0110, DATA_W data bits MSB first, odd parity, stop 1.
// The line idles at 1. Each line bit lasts CLKS_PER_BIT cycles.
//   clk, rst : clock, asynchronous active-high reset
//   tx       : payload handshake (frame_tx_if.slave)
//   out_o    : registered serial line
//   busy_o   : frame in progress (SYNC through STOP)
//   done_o   : one-cycle pulse in the final cycle of the stop bit
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  frame_tx_if.slave   tx,
  output logic        out_o,
  output logic        busy_o,
  output logic        done_o
);
  // One index counter serves both the header and the payload.
  localparam int IDX_MAX = (DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN;
  localparam int IDX_W   = $clog2(IDX_MAX);
  localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNC_LEN - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);

  ftx_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_q, out_d;
  logic              tick, ready, accept;

  // Ready is gated by rst directly so it reads 0 for the whole reset interval.
  assign ready       = !rst && ((state_q == FTX_IDLE) || ((state_q == FTX_STOP) && tick));
  assign accept      = tx.tx_valid && ready;
  assign tx.tx_ready = ready;

  assign out_o  = out_q;
  assign busy_o = (state_q != FTX_IDLE);
  assign done_o = (state_q == FTX_STOP) && tick;

  // Bit timing restarts on every acceptance; holding it clear in IDLE keeps the
  // first bit of a frame a full period long.
  frame_tx_bit_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_tick (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept || (state_q == FTX_IDLE)),
    .strike_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    idx_d   = idx_q;
    case (state_q)
      FTX_IDLE: ;
      FTX_SYNC:
        if (tick) begin
          if (idx_q == SYNC_LAST) begin
            state_d = FTX_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      FTX_DATA:
        if (tick) begin
          shreg_d = shreg_q << 1;
          if (idx_q == DATA_LAST) begin
            state_d = FTX_PARITY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      FTX_PARITY:
        if (tick) state_d = FTX_STOP;
      FTX_STOP:
        if (tick) state_d = FTX_IDLE;
      default: state_d = FTX_IDLE;
    endcase

    // Acceptance (IDLE or last STOP cycle) overrides the above and starts a frame.
    if (accept) begin
      state_d = FTX_SYNC;
      idx_d   = '0;
      shreg_d = tx.tx_data;
      par_d   = ~^tx.tx_data;
    end

    // The line register takes the bit that belongs to the next cycle's position,
    // so out changes on the same edge as the state.
    case (state_d)
      FTX_SYNC:   out_d = sync_bit(idx_d[1:0]);
      FTX_DATA:   out_d = shreg_d[DATA_W-1];
      FTX_PARITY: out_d = par_d;
      default:    out_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FTX_IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      out_q   <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: directed + random bench for frame_tx. Two instances share clk/rst:
// u1 with one cycle per bit (also feeds a far-end 0110 detector model) and u3
// with three cycles per bit.
module tb_frame_tx;
  localparam int FLEN = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_tx_if #(.DATA_W(8)) if1 ();
  frame_tx_if #(.DATA_W(8)) if3 ();
  logic out1, busy1, done1, out3, busy3, done3;

  frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst(rst), .tx(if1), .out_o(out1), .busy_o(busy1), .done_o(done1));
  frame_tx #(.DATA_W(8), .CLKS_PER_BIT(3)) u3 (
    .clk(clk), .rst(rst), .tx(if3), .out_o(out3), .busy_o(busy3), .done_o(done3));

  int total = 0;
  int bad   = 0;

  // Far-end overlapping 0110 detector on u1's line: flags the cycle after the
  // last pattern bit was on the line.
  logic [3:0] win_q;
  logic       det_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= 4'hF;
      det_q <= 1'b0;
    end else begin
      win_q <= {win_q[2:0], out1};
      det_q <= ({win_q[2:0], out1} == 4'b0110);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  // Reference frame, first line bit at [13]: sync, data MSB first, parity making
  // the count of ones over data+parity odd, stop.
  function automatic logic [13:0] frame_bits(input logic [7:0] w);
    logic par;
    par = ($countones(w) % 2 == 0);
    return {4'b0110, w, par, 1'b1};
  endfunction

  function automatic logic o_out(input int k);  return (k == 1) ? out1  : out3;  endfunction
  function automatic logic o_busy(input int k); return (k == 1) ? busy1 : busy3; endfunction
  function automatic logic o_done(input int k); return (k == 1) ? done1 : done3; endfunction
  function automatic logic o_rdy(input int k);  return (k == 1) ? if1.tx_ready : if3.tx_ready; endfunction

  task automatic drive(input int k, input logic v, input logic [7:0] d);
    if (k == 1) begin if1.tx_valid = v; if1.tx_data = d; end
    else        begin if3.tx_valid = v; if3.tx_data = d; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send n (1 or 2) frames back to back on instance k (K cycles per bit) and
  // check every cycle against the reference frame stream.
  task automatic run(input string tag, input int k, input int K, input int n,
                     input logic [7:0] w0, input logic [7:0] w1);
    logic [27:0] want;
    int len;
    int dones;
    want  = {frame_bits(w0), frame_bits(w1)};
    len   = n * FLEN * K;
    dones = 0;
    chk({tag, "/rdy_pre"}, o_rdy(k), 1);
    drive(k, 1'b1, w0);
    step();
    for (int i = 0; i < len; i++) begin
      int  bit_no;
      logic last;
      bit_no = i / K;
      last   = ((i % (FLEN * K)) == FLEN * K - 1);
      if (n == 2 && i == 0)            drive(k, 1'b1, w1);
      else if (i >= (n - 1) * FLEN * K) drive(k, 1'b0, 8'($urandom));
      chk({tag, "/out"},  o_out(k),  want[27 - bit_no]);
      chk({tag, "/busy"}, o_busy(k), 1);
      chk({tag, "/done"}, o_done(k), last);
      chk({tag, "/rdy"},  o_rdy(k),  last);
      if (o_done(k)) dones++;
      step();
    end
    chk({tag, "/idle_out"},  o_out(k),  1);
    chk({tag, "/idle_busy"}, o_busy(k), 0);
    chk({tag, "/idle_done"}, o_done(k), 0);
    chk({tag, "/done_cnt"},  dones,     n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    drive(1, 1'b0, 8'h00);
    drive(3, 1'b0, 8'h00);

    // Reset and idle.
    #1 rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst/out1", out1, 1);   chk("rst/busy1", busy1, 0);
      chk("rst/done1", done1, 0); chk("rst/rdy1", if1.tx_ready, 0);
      chk("rst/out3", out3, 1);   chk("rst/busy3", busy3, 0);
      chk("rst/done3", done3, 0); chk("rst/rdy3", if3.tx_ready, 0);
      step();
    end
    rst = 1'b0;
    #1;
    chk("rel/rdy1", if1.tx_ready, 1);
    chk("rel/rdy3", if3.tx_ready, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle/out1", out1, 1);   chk("idle/busy1", busy1, 0);
      chk("idle/done1", done1, 0); chk("idle/out3", out3, 1);
    end

    // Single frame, parity with 3 cycles per bit, back-to-back.
    run("a5", 1, 1, 1, 8'hA5, 8'h00);
    run("p01", 3, 3, 1, 8'h01, 8'h00);
    run("p00", 3, 3, 1, 8'h00, 8'h00);
    run("b2b", 1, 1, 2, 8'hFF, 8'h3C);
    run("b2b3", 3, 3, 2, 8'($urandom), 8'($urandom));

    // Reset during DATA bit 3 of A5.
    drive(1, 1'b1, 8'hA5);
    step();
    drive(1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) step();
    chk("mid/out_b3", out1, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid/out", out1, 1);
    chk("mid/busy", busy1, 0);
    chk("mid/done", done1, 0);
    chk("mid/rdy", if1.tx_ready, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("mid/hold_out", out1, 1);
      chk("mid/hold_done", done1, 0);
    end
    rst = 1'b0;
    step();
    run("post_rst", 1, 1, 1, 8'h5A, 8'h00);

    // Loopback into the far-end detector.
    step();
    hits = 0;
    chk("lb/det_idle", det_q, 0);
    drive(1, 1'b1, 8'hA5);
    step();
    drive(1, 1'b0, 8'h00);
    for (int i = 0; i < FLEN + 4; i++) begin
      chk("lb/det", det_q, (i == 4));
      if (det_q) hits++;
      step();
    end
    chk("lb/hits", hits, 1);

    // Random payloads on both instances.
    for (int r = 0; r < 6; r++) run("rnd1", 1, 1, 1, 8'($urandom_range(0, 255)), 8'h00);
    for (int r = 0; r < 3; r++) run("rnd3", 3, 3, 1, 8'($urandom_range(0, 255)), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
